// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache refill path.
package cache_pkg;

  localparam int unsigned DEF_CACHELINE_WD = 512;
  localparam int unsigned DEF_DATA_WD      = 32;
  localparam int unsigned BEATS            = DEF_CACHELINE_WD / DEF_DATA_WD;

  // Beat index width, never narrower than one bit.
  function automatic int unsigned beat_idx_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned BEAT_IDX_W = beat_idx_w(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_DATA,
    WB_RESP,
    RD_REQ,
    RD_DATA,
    REFILL
  } refill_state_t;

endpackage

// File: rtl/line_shift_buf.sv
// Cache-line buffer: whole-line load, beat-indexed write, beat-indexed read mux.
module line_shift_buf #(
  parameter int unsigned LINE_WD = 512,
  parameter int unsigned BEAT_WD = 32,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LINE_WD-1:0] load_line,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BEAT_WD-1:0] wr_beat,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [LINE_WD-1:0] line,
  output logic [BEAT_WD-1:0] rd_beat
);

  logic [LINE_WD-1:0] line_q;

  // Line storage: full load wins over a single-beat write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q[wr_idx*BEAT_WD +: BEAT_WD] <= wr_beat;
    end
  end

  // Beat read mux and full-line view.
  always_comb begin
    line    = line_q;
    rd_beat = line_q[rd_idx*BEAT_WD +: BEAT_WD];
  end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss sequencer: optional dirty-victim write-back burst, then
// line read burst, then a one-cycle install strobe.
// Optional feature macro: DCACHE_CTRL_PERF_EN (miss / write-back counters).
module dcache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned CACHELINE_WD = DEF_CACHELINE_WD,
  parameter int unsigned DATA_WD      = DEF_DATA_WD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dcache_miss,
  input  logic                    dcache_write_back,
  input  logic [31:0]             dcache_raddr,
  input  logic [31:0]             dcache_waddr,
  input  logic [CACHELINE_WD-1:0] dcache_cacheline_old,
  output logic                    dcache_refresh,
  output logic [CACHELINE_WD-1:0] dcache_cacheline_new,
  output logic                    busy,
  output logic                    rd_req,
  output logic [31:0]             rd_addr,
  input  logic                    rd_addr_ok,
  input  logic                    rd_valid,
  input  logic [DATA_WD-1:0]      rd_data,
  input  logic                    rd_last,
  output logic                    wr_req,
  output logic [31:0]             wr_addr,
  input  logic                    wr_addr_ok,
  output logic                    wr_valid,
  output logic [DATA_WD-1:0]      wr_data,
  output logic                    wr_last,
  input  logic                    wr_ready,
  input  logic                    wr_done,
  output logic [31:0]             perf_miss_cnt,
  output logic [31:0]             perf_wb_cnt
);

  localparam int unsigned      NBEATS    = CACHELINE_WD / DATA_WD;
  localparam int unsigned      IDX_W     = beat_idx_w(NBEATS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NBEATS - 1);

  refill_state_t             state, state_next;
  logic [IDX_W-1:0]          beat;
  logic                      line_full;
  logic [31:0]               raddr_q, waddr_q;
  logic                      sample, wb_enter, rd_enter, wr_acc, rd_acc;
  logic [CACHELINE_WD-1:0]   line;
  logic [DATA_WD-1:0]        beat_data;

  assign sample   = (state == IDLE)    && dcache_miss;
  assign wb_enter = (state == WB_REQ)  && wr_addr_ok;
  assign rd_enter = (state == RD_REQ)  && rd_addr_ok;
  assign wr_acc   = (state == WB_DATA) && wr_ready;
  assign rd_acc   = (state == RD_DATA) && rd_valid && !line_full;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; RD_DATA holds one cycle after the last beat so the
  // install strobe lands BEATS+2 cycles after the read request is entered.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dcache_miss) state_next = dcache_write_back ? WB_REQ : RD_REQ;
      WB_REQ:  if (wr_addr_ok) state_next = WB_DATA;
      WB_DATA: if (wr_ready && (beat == LAST_BEAT)) state_next = WB_RESP;
      WB_RESP: if (wr_done) state_next = RD_REQ;
      RD_REQ:  if (rd_addr_ok) state_next = RD_DATA;
      RD_DATA: if (line_full) state_next = REFILL;
      REFILL:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are pure functions of state so reset forces them low at once.
  always_comb begin
    busy                 = (state != IDLE);
    wr_req               = 1'b0;
    wr_addr              = '0;
    wr_valid             = 1'b0;
    wr_data              = '0;
    wr_last              = 1'b0;
    rd_req               = 1'b0;
    rd_addr              = '0;
    dcache_refresh       = 1'b0;
    dcache_cacheline_new = '0;
    case (state)
      WB_REQ: begin
        wr_req  = 1'b1;
        wr_addr = waddr_q;
      end
      WB_DATA: begin
        wr_valid = 1'b1;
        wr_data  = beat_data;
        wr_last  = (beat == LAST_BEAT);
      end
      RD_REQ: begin
        rd_req  = 1'b1;
        rd_addr = raddr_q;
      end
      REFILL: begin
        dcache_refresh       = 1'b1;
        dcache_cacheline_new = line;
      end
      default: ;
    endcase
  end

  // Request addresses captured once per miss; later input changes ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_q <= '0;
      waddr_q <= '0;
    end else if (sample) begin
      raddr_q <= dcache_raddr;
      waddr_q <= dcache_waddr;
    end
  end

  // Beat counter saturates at the last beat; line_full marks the read burst done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat      <= '0;
      line_full <= 1'b0;
    end else begin
      if (wb_enter || rd_enter) begin
        beat <= '0;
      end else if ((wr_acc || rd_acc) && (beat != LAST_BEAT)) begin
        beat <= beat + 1'b1;
      end
      if (rd_enter) begin
        line_full <= 1'b0;
      end else if (rd_acc && (beat == LAST_BEAT)) begin
        line_full <= 1'b1;
      end
    end
  end

  // Victim line is loaded on the sample cycle, then overwritten beat by beat.
  line_shift_buf #(
    .LINE_WD (CACHELINE_WD),
    .BEAT_WD (DATA_WD),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (reset),
    .load      (sample),
    .load_line (dcache_cacheline_old),
    .wr_en     (rd_acc),
    .wr_idx    (beat),
    .wr_beat   (rd_data),
    .rd_idx    (beat),
    .line      (line),
    .rd_beat   (beat_data)
  );

`ifdef DCACHE_CTRL_PERF_EN
  // Miss and write-back event counters, free-running with wrap-around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else begin
      if (sample) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if ((state == WB_RESP) && wr_done) perf_wb_cnt <= perf_wb_cnt + 32'd1;
    end
  end
`else
  assign perf_miss_cnt = '0;
  assign perf_wb_cnt   = '0;
`endif

`ifndef SYNTHESIS
  // The bridge's last-beat flag must agree with the beat counter.
  a_rd_last: assert property (@(posedge clk) disable iff (reset)
    rd_acc |-> (rd_last == (beat == LAST_BEAT)));
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: bus responder plus line-level model.
module tb_dcache_refill_ctrl;
  import cache_pkg::*;

  localparam int unsigned LW = 512;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = LW / DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          dcache_miss, dcache_write_back;
  logic [31:0]   dcache_raddr, dcache_waddr;
  logic [LW-1:0] dcache_cacheline_old;
  logic          dcache_refresh;
  logic [LW-1:0] dcache_cacheline_new;
  logic          busy;
  logic          rd_req, rd_addr_ok, rd_valid, rd_last;
  logic [31:0]   rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_addr_ok, wr_valid, wr_last, wr_ready, wr_done;
  logic [31:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   perf_miss_cnt, perf_wb_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_miss = 0;
  int exp_wb   = 0;

  always #5 clk = ~clk;

  dcache_refill_ctrl #(
    .CACHELINE_WD (LW),
    .DATA_WD      (DW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .dcache_miss          (dcache_miss),
    .dcache_write_back    (dcache_write_back),
    .dcache_raddr         (dcache_raddr),
    .dcache_waddr         (dcache_waddr),
    .dcache_cacheline_old (dcache_cacheline_old),
    .dcache_refresh       (dcache_refresh),
    .dcache_cacheline_new (dcache_cacheline_new),
    .busy                 (busy),
    .rd_req               (rd_req),
    .rd_addr              (rd_addr),
    .rd_addr_ok           (rd_addr_ok),
    .rd_valid             (rd_valid),
    .rd_data              (rd_data),
    .rd_last              (rd_last),
    .wr_req               (wr_req),
    .wr_addr              (wr_addr),
    .wr_addr_ok           (wr_addr_ok),
    .wr_valid             (wr_valid),
    .wr_data              (wr_data),
    .wr_last              (wr_last),
    .wr_ready             (wr_ready),
    .wr_done              (wr_done),
    .perf_miss_cnt        (perf_miss_cnt),
    .perf_wb_cnt          (perf_wb_cnt)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int unsigned k = 0; k < NB; k++) l[k*DW +: DW] = $urandom;
    return l;
  endfunction

  // 0: every cycle, 1: alternate cycles, 2: one cycle in three, other: random
  function automatic bit pace(input int mode, input int ph);
    case (mode)
      0:       return 1'b1;
      1:       return (ph % 2) == 0;
      2:       return (ph % 3) == 0;
      default: return ($urandom % 2) == 1;
    endcase
  endfunction

  task automatic clear_bus();
    rd_addr_ok = 1'b0; rd_valid = 1'b0; rd_data = '0; rd_last = 1'b0;
    wr_addr_ok = 1'b0; wr_ready = 1'b0; wr_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {busy, dcache_refresh, rd_req, wr_req, wr_valid, wr_last}, '0);
    check({tag, "_line"}, dcache_cacheline_new, '0);
    check({tag, "_bus"}, {rd_addr, wr_addr, wr_data}, '0);
    check({tag, "_perf"}, {perf_miss_cnt, perf_wb_cnt}, '0);
  endtask

  task automatic check_perf(input string tag);
`ifdef DCACHE_CTRL_PERF_EN
    check({tag, "_miss"}, perf_miss_cnt, exp_miss);
    check({tag, "_wb"}, perf_wb_cnt, exp_wb);
`else
    check({tag, "_miss"}, perf_miss_cnt, 0);
    check({tag, "_wb"}, perf_wb_cnt, 0);
`endif
  endtask

  // One miss acting as cache and bus bridge; called right after a negedge.
  task automatic run_miss(input bit dirty, input logic [31:0] ra, input logic [31:0] wa,
                          input logic [LW-1:0] old_l, input logic [LW-1:0] new_l,
                          input int mode, input bit zero_wait, input bit disturb,
                          input int abort_beat);
    int wcnt, rcnt, wph, rph, wr_grants, rd_grants, refreshes, busy_gaps, extra, lat, done_wait, bad;
    bit rd_active, wdone_given, seen, finished, aborted, post_busy, last_exp;
    logic [LW-1:0] got_line;
    wcnt = 0; rcnt = 0; wph = 0; rph = 0; wr_grants = 0; rd_grants = 0; refreshes = 0;
    busy_gaps = 0; extra = 0; lat = -1; done_wait = $urandom_range(0, 3);
    rd_active = 0; wdone_given = 0; seen = 0; finished = 0; aborted = 0; post_busy = 1;
    got_line = '0;

    dcache_miss = 1'b1; dcache_write_back = dirty;
    dcache_raddr = ra; dcache_waddr = wa; dcache_cacheline_old = old_l;
    exp_miss++;

    for (int n = 0; n < 400 && !finished; n++) begin
      @(negedge clk);
      clear_bus();
      rd_data = $urandom;
      if (disturb) begin
        dcache_raddr = $urandom; dcache_waddr = $urandom;
        dcache_write_back = ($urandom % 2) == 1; dcache_cacheline_old = rand_line();
      end

      if (dcache_refresh) begin
        refreshes++;
        if (!seen) begin got_line = dcache_cacheline_new; lat = n; end
        seen = 1; dcache_miss = 1'b0;
      end else if (seen) begin
        finished = 1; post_busy = busy;
      end else if (!busy) begin
        busy_gaps++;
      end

      // write side
      if (wr_req) begin
        wr_addr_ok = zero_wait || (($urandom % 2) == 1);
        if (wr_addr_ok) begin wr_grants++; check("wr_addr", wr_addr, wa); end
      end else if (wr_valid) begin
        if (wcnt < int'(NB)) begin
          last_exp = (wcnt == int'(NB) - 1);
          check($sformatf("wr_beat%0d", wcnt), {wr_last, wr_data}, {last_exp, old_l[wcnt*DW +: DW]});
        end else extra++;
        wr_ready = pace(mode, wph); wph++;
        if (wr_ready) wcnt++;
        wr_done = ($urandom % 2) == 1;
      end else begin
        wr_ready = ($urandom % 2) == 1;
        if (wcnt == int'(NB) && !wdone_given) begin
          if (done_wait == 0) begin wr_done = 1'b1; wdone_given = 1; exp_wb++; end
          else done_wait--;
        end
      end

      // read side
      if (rd_req) begin
        rd_addr_ok = zero_wait || (($urandom % 3) == 0);
        if (rd_addr_ok) begin
          rd_grants++; rd_active = 1;
          check("rd_addr", rd_addr, ra);
          check("rd_after_wb_done", wdone_given, dirty);
        end
      end else if (rd_active && rcnt < int'(NB)) begin
        if (rcnt == abort_beat) begin
          reset = 1'b1;
          #1;
          check_all_zero("abort");
          dcache_miss = 1'b0; exp_miss = 0; exp_wb = 0;
          aborted = 1; finished = 1;
          @(negedge clk);
          reset = 1'b0;
        end else begin
          rd_valid = pace(mode, rph); rph++;
          if (rd_valid) begin
            rd_data = new_l[rcnt*DW +: DW];
            rd_last = (rcnt == int'(NB) - 1);
            rcnt++;
          end
        end
      end else begin
        rd_valid = ($urandom % 2) == 1;
      end
    end

    clear_bus();
    if (!aborted) begin
      check("finished", finished, 1);
      check("refresh_pulses", refreshes, 1);
      check("line", got_line, new_l);
      check("wr_beats", wcnt + extra, dirty ? NB : 0);
      check("wr_grants", wr_grants, dirty);
      check("rd_grants", rd_grants, 1);
      check("busy_until_refill", busy_gaps, 0);
      check("idle_after_refill", post_busy, 0);
      if (zero_wait) check("latency", lat, NB + 2);
      bad = 0;
      repeat (3) begin
        @(negedge clk);
        if (busy || rd_req || wr_req || dcache_refresh) bad++;
      end
      check("no_second_request", bad, 0);
    end
  endtask

  initial begin
    logic [LW-1:0] seq_line, a0_line;
    reset = 1'b1;
    dcache_miss = 1'b0; dcache_write_back = 1'b0;
    dcache_raddr = '0; dcache_waddr = '0; dcache_cacheline_old = '0;
    clear_bus();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int unsigned k = 0; k < NB; k++) begin
      seq_line[k*DW +: DW] = k;
      a0_line[k*DW +: DW]  = 32'hA0 + k;
    end

    // clean miss, zero wait, word k = k
    run_miss(0, 32'h0000_2000, 32'h0, rand_line(), seq_line, 0, 1, 0, -1);
    // dirty miss, toggling handshakes
    run_miss(1, 32'h0000_3000, 32'h0000_1000, a0_line, rand_line(), 1, 0, 0, -1);
    // read gaps one in three
    run_miss(0, $urandom, $urandom, rand_line(), rand_line(), 2, 0, 0, -1);
    // inputs changing mid-operation with miss still held
    run_miss(1, $urandom, $urandom, rand_line(), rand_line(), 3, 0, 1, -1);
    check_perf("perf_mid");

    // reset during read beat 7, then full refills
    run_miss(0, $urandom, $urandom, rand_line(), rand_line(), 0, 1, 0, 7);
    run_miss(0, $urandom, $urandom, rand_line(), rand_line(), 0, 1, 0, -1);
    run_miss(1, $urandom, $urandom, rand_line(), rand_line(), 3, 0, 0, -1);
    run_miss(0, $urandom, $urandom, rand_line(), rand_line(), 2, 0, 0, -1);
    check_perf("perf_three");

    for (int unsigned i = 0; i < 6; i++)
      run_miss(($urandom % 2) == 1, $urandom, $urandom, rand_line(), rand_line(),
               $urandom_range(0, 3), 0, ($urandom % 2) == 1, -1);
    check_perf("perf_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
